// File: rtl/ps_pkg.sv
// Shared constants and width helpers for the pixel-stream blocks.
// Widths are floored at 1 so that degenerate 1-pixel dimensions still give legal vectors.
package ps_pkg;

    localparam int unsigned PS_LINE_LENGTH = 640;
    localparam int unsigned PS_LINE_COUNT  = 480;

    function automatic int unsigned ps_x_w(input int unsigned line_length);
        return (line_length > 1) ? $clog2(line_length) : 1;
    endfunction

    function automatic int unsigned ps_y_w(input int unsigned line_count);
        return (line_count > 1) ? $clog2(line_count) : 1;
    endfunction

    function automatic int unsigned ps_cnt_w(input int unsigned line_length,
                                             input int unsigned line_count);
        longint unsigned pixels;
        pixels = longint'(line_length) * longint'(line_count) + 1;
        return $clog2(pixels);
    endfunction

endpackage

// File: rtl/ps_popcount9.sv
// Combinational population count of a 9-bit window mask (result 0..9).
module ps_popcount9 (
    input  logic [8:0] i_bits,
    output logic [3:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            o_count = o_count + 4'(i_bits[i]);
        end
    end

endmodule

// File: rtl/ps_morph_bbox.sv
// 3x3 threshold morphology filter with per-frame bounding box and set-pixel count.
// Two-stage pipeline; x/y counters track the pixel currently on o_data.
module ps_morph_bbox
    import ps_pkg::*;
#(
    parameter  int unsigned LINE_LENGTH = PS_LINE_LENGTH,
    parameter  int unsigned LINE_COUNT  = PS_LINE_COUNT,
    parameter  int unsigned DATA_WIDTH  = 1,
    parameter  int unsigned THRESH      = 5,
    localparam int unsigned X_W         = ps_x_w(LINE_LENGTH),
    localparam int unsigned Y_W         = ps_y_w(LINE_COUNT),
    localparam int unsigned CNT_W       = ps_cnt_w(LINE_LENGTH, LINE_COUNT)
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic [3*DATA_WIDTH-1:0] i_r0_data,
    input  logic [3*DATA_WIDTH-1:0] i_r1_data,
    input  logic [3*DATA_WIDTH-1:0] i_r2_data,
    input  logic                    i_valid,
    output logic                    o_data,
    output logic                    o_valid,
    output logic                    o_sof,
    output logic                    o_eol,
    output logic                    o_bbox_valid,
    output logic [X_W-1:0]          o_x_min,
    output logic [X_W-1:0]          o_x_max,
    output logic [Y_W-1:0]          o_y_min,
    output logic [Y_W-1:0]          o_y_max,
    output logic [CNT_W-1:0]        o_count,
    output logic                    o_bbox_empty
);

    localparam logic [X_W-1:0] X_LAST = X_W'(LINE_LENGTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(LINE_COUNT - 1);

    logic [8:0]       win_bits;
    logic [3:0]       popcnt;

    logic [3:0]       pc_q,    pc_d;
    logic             v1_q,    v1_d;
    logic             data_q,  data_d;
    logic             valid_q, valid_d;
    logic [X_W-1:0]   x_q,     x_d;
    logic [Y_W-1:0]   y_q,     y_d;
    logic [X_W-1:0]   xmin_q,  xmin_d;
    logic [X_W-1:0]   xmax_q,  xmax_d;
    logic [Y_W-1:0]   ymin_q,  ymin_d;
    logic [Y_W-1:0]   ymax_q,  ymax_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [X_W-1:0]   rxmin_q, rxmin_d;
    logic [X_W-1:0]   rxmax_q, rxmax_d;
    logic [Y_W-1:0]   rymin_q, rymin_d;
    logic [Y_W-1:0]   rymax_q, rymax_d;
    logic [CNT_W-1:0] rcnt_q,  rcnt_d;
    logic             empty_q, empty_d;
    logic             bbv_q,   bbv_d;

    logic             hit;
    logic             last;
    logic [X_W-1:0]   m_xmin, m_xmax;
    logic [Y_W-1:0]   m_ymin, m_ymax;
    logic [CNT_W-1:0] m_cnt;

    always_comb begin
        win_bits = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            win_bits[i]     = |i_r0_data[i*DATA_WIDTH +: DATA_WIDTH];
            win_bits[3 + i] = |i_r1_data[i*DATA_WIDTH +: DATA_WIDTH];
            win_bits[6 + i] = |i_r2_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    ps_popcount9 u_popcount (
        .i_bits  (win_bits),
        .o_count (popcnt)
    );

    always_comb begin
        pc_d    = popcnt;
        v1_d    = i_valid;
        data_d  = (pc_q >= 4'(THRESH));
        valid_d = v1_q;

        x_d = x_q;
        y_d = y_q;
        if (valid_q) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        // Merged view includes the pixel on o_data, so the frame's last pixel lands in the results.
        hit    = valid_q & data_q;
        last   = valid_q && (x_q == X_LAST) && (y_q == Y_LAST);
        m_xmin = (hit && (x_q < xmin_q)) ? x_q : xmin_q;
        m_xmax = (hit && (x_q > xmax_q)) ? x_q : xmax_q;
        m_ymin = (hit && (y_q < ymin_q)) ? y_q : ymin_q;
        m_ymax = (hit && (y_q > ymax_q)) ? y_q : ymax_q;
        m_cnt  = cnt_q + CNT_W'(hit);

        xmin_d  = m_xmin;
        xmax_d  = m_xmax;
        ymin_d  = m_ymin;
        ymax_d  = m_ymax;
        cnt_d   = m_cnt;
        rxmin_d = rxmin_q;
        rxmax_d = rxmax_q;
        rymin_d = rymin_q;
        rymax_d = rymax_q;
        rcnt_d  = rcnt_q;
        empty_d = empty_q;
        bbv_d   = last;

        if (last) begin
            xmin_d = X_LAST;
            xmax_d = '0;
            ymin_d = Y_LAST;
            ymax_d = '0;
            cnt_d  = '0;
            rcnt_d = m_cnt;
            if (m_cnt == '0) begin
                rxmin_d = '0;
                rxmax_d = '0;
                rymin_d = '0;
                rymax_d = '0;
                empty_d = 1'b1;
            end else begin
                rxmin_d = m_xmin;
                rxmax_d = m_xmax;
                rymin_d = m_ymin;
                rymax_d = m_ymax;
                empty_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            pc_q    <= '0;
            v1_q    <= 1'b0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            xmin_q  <= X_LAST;
            xmax_q  <= '0;
            ymin_q  <= Y_LAST;
            ymax_q  <= '0;
            cnt_q   <= '0;
            rxmin_q <= '0;
            rxmax_q <= '0;
            rymin_q <= '0;
            rymax_q <= '0;
            rcnt_q  <= '0;
            empty_q <= 1'b0;
            bbv_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            v1_q    <= v1_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            cnt_q   <= cnt_d;
            rxmin_q <= rxmin_d;
            rxmax_q <= rxmax_d;
            rymin_q <= rymin_d;
            rymax_q <= rymax_d;
            rcnt_q  <= rcnt_d;
            empty_q <= empty_d;
            bbv_q   <= bbv_d;
        end
    end

    always_comb begin
        o_data       = data_q;
        o_valid      = valid_q;
        o_sof        = valid_q && (x_q == '0) && (y_q == '0);
        o_eol        = valid_q && (x_q == X_LAST);
        o_bbox_valid = bbv_q;
        o_x_min      = rxmin_q;
        o_x_max      = rxmax_q;
        o_y_min      = rymin_q;
        o_y_max      = rymax_q;
        o_count      = rcnt_q;
        o_bbox_empty = empty_q;
    end

endmodule

// File: doc/ps_morph_bbox.md
PS_MORPH_BBOX -- requirements
Module: ps_morph_bbox

Interface
REQ-001 Parameter LINE_LENGTH, default 640, pixels per line.
REQ-002 Parameter LINE_COUNT, default 480, lines per frame.
REQ-003 Parameter DATA_WIDTH, default 1, bits per pixel lane.
REQ-004 Parameter THRESH, default 5, minimum set pixels in the 3x3 window for output = 1 (range 1..9: 9 = erode, 1 = dilate, 5 = majority).
REQ-005 i_clk  in  1  clock; all logic rising-edge.
REQ-006 i_rstn  in  1  reset, synchronous, active-low.
REQ-007 i_r0_data  in  3*DATA_WIDTH  window top row; lane0 = left, lane2 = right.
REQ-008 i_r1_data  in  3*DATA_WIDTH  window centre row, same lane order.
REQ-009 i_r2_data  in  3*DATA_WIDTH  window bottom row, same lane order.
REQ-010 i_valid  in  1  window valid this cycle.
REQ-011 o_data  out  1  filtered pixel.
REQ-012 o_valid  out  1  o_data valid.
REQ-013 o_sof  out  1  with o_valid: pixel (0,0).
REQ-014 o_eol  out  1  with o_valid: pixel x = LINE_LENGTH-1.
REQ-015 o_bbox_valid  out  1  one-cycle pulse, frame results valid.
REQ-016 o_x_min, o_x_max  out  X_W  bounding-box columns.
REQ-017 o_y_min, o_y_max  out  Y_W  bounding-box rows.
REQ-018 o_count  out  CNT_W  set output pixels in frame.
REQ-019 o_bbox_empty  out  1  frame had zero set output pixels.

Function
REQ-020 Lane is "set" when its DATA_WIDTH-bit value is nonzero.
REQ-021 Stage 1 registers popcount (0..9) of the 9 set bits and i_valid; stage 2 registers o_data = (popcount >= THRESH) and o_valid; latency exactly 2 cycles, throughput 1 window/cycle.
REQ-022 Input gaps pass through as o_valid gaps; no backpressure, no data loss.
REQ-023 Column counter x (0..LINE_LENGTH-1) and row counter y (0..LINE_COUNT-1) describe the pixel currently on o_data; x advances after each o_valid, wraps to 0 after LINE_LENGTH-1 and advances y; y wraps to 0 after LINE_COUNT-1.
REQ-024 o_sof = o_valid & x==0 & y==0; o_eol = o_valid & x==LINE_LENGTH-1.
REQ-025 Accumulators init: xmin = LINE_LENGTH-1, ymin = LINE_COUNT-1, xmax = ymax = 0, count = 0.
REQ-026 On o_valid & o_data: xmin = min(xmin,x), xmax = max(xmax,x), ymin = min(ymin,y), ymax = max(ymax,y), count += 1.
REQ-027 On the edge after the last frame pixel (x = LINE_LENGTH-1, y = LINE_COUNT-1) leaves o_data: result registers load the final values including that pixel, o_bbox_valid = 1 for one cycle, accumulators return to init.
REQ-028 A pixel of the next frame on the cycle immediately after the last pixel accumulates into the fresh accumulators; results of both frames remain correct.
REQ-029 Empty frame: o_bbox_empty = 1; o_x_min, o_x_max, o_y_min and o_y_max = 0; o_count = 0.
REQ-030 Result outputs hold until the next o_bbox_valid.
REQ-031 X_W = clog2(LINE_LENGTH), Y_W = clog2(LINE_COUNT), CNT_W = clog2(LINE_LENGTH*LINE_COUNT+1); count never wraps.

Reset
REQ-032 Reset: all outputs 0, pipeline valids 0, x = y = 0, accumulators at init.
REQ-033 Reset mid-frame discards the partial frame; no o_bbox_valid for it.

Structure
REQ-034 Shared package ps_pkg holds the width functions (X_W, Y_W, CNT_W) and the default LINE_LENGTH and LINE_COUNT constants.
REQ-035 One sub-module, ps_popcount9: combinational 9-input popcount, 4-bit result.

Verification (bench uses LINE_LENGTH = 8, LINE_COUNT = 6)
REQ-036 Single window with all 9 pixels set, THRESH = 5 -> o_data = 1 and o_valid exactly 2 cycles later; 4 set -> o_data = 0.
REQ-037 Continuous 48-pixel frame -> o_sof on pixel 0 only, o_eol on pixels 7, 15, ... 47, o_bbox_valid one cycle after pixel 47.
REQ-038 Frame with set outputs only at (2,1), (5,4) -> x_min 2, x_max 5, y_min 1, y_max 4, count 2, empty 0.
REQ-039 All-zero frame -> bbox_empty 1, count 0, all min/max outputs 0.
REQ-040 Two back-to-back frames (no gap), frame 2 with its only set pixel at (0,0) -> frame 2 result x/y min/max 0, count 1.
REQ-041 Reset asserted at pixel 20, then a full frame -> no pulse for the partial frame; the next pulse covers only the new frame.
